// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and the operand magnitude helper used when latching operands.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Widest operand the magnitude helper handles; callers extend their
    // operand to this width (sign or zero fill) and truncate the result.
    localparam int MAX_WIDTH = 32;

    // Magnitude of an already-extended operand. The most-negative value of a
    // narrower operand becomes 2^(WIDTH-1), which still fits in WIDTH bits.
    function automatic logic [MAX_WIDTH-1:0] abs_mag(
        input logic [MAX_WIDTH-1:0] value,
        input logic                 is_signed
    );
        if (is_signed && value[MAX_WIDTH-1]) begin
            return -value;
        end
        return value;
    endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Datapath of the shift-add multiplier: holds accumulator, shifting
// multiplicand/multiplier, step counter, result sign and the output product.
// The FSM drives it with one-hot load/step/fix strobes.
module seq_mult_datapath
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               fix,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               last_step,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [CNT_W-1:0]     count;
    logic                 neg;

    logic [MAX_WIDTH-1:0] ext_a;
    logic [MAX_WIDTH-1:0] ext_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 neg_in;
    logic [2*WIDTH-1:0]   acc_next;

    // Operand conditioning: extend per mode, take magnitudes, derive result sign.
    always_comb begin
        ext_a  = signed_mode ? MAX_WIDTH'(signed'(a)) : MAX_WIDTH'(a);
        ext_b  = signed_mode ? MAX_WIDTH'(signed'(b)) : MAX_WIDTH'(b);
        mag_a  = WIDTH'(abs_mag(ext_a, signed_mode));
        mag_b  = WIDTH'(abs_mag(ext_b, signed_mode));
        neg_in = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    end

    // One partial-product step: add the shifted multiplicand when the current
    // multiplier bit is set. The final step is flagged so the FSM can leave RUN.
    always_comb begin
        acc_next  = acc + (mplier[0] ? mcand : '0);
        last_step = (count == CNT_W'(WIDTH - 1));
    end

    // Iteration registers: cleared and loaded on start, advanced once per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            neg    <= 1'b0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            count  <= '0;
            neg    <= neg_in;
        end else if (step) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CNT_W'(1);
        end
    end

    // Result register: written only in FIX so the product holds through IDLE,
    // DONE and the whole of the next operation until its own FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
        end else if (fix) begin
            product <= neg ? -acc : acc;
        end
    end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier top level: start/busy/done handshake FSM
// around the datapath. One operation takes WIDTH steps plus a sign fix cycle.
module seq_shift_add_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    state_t state;
    state_t next_state;
    logic   load;
    logic   step;
    logic   fix;
    logic   last_step;

    seq_mult_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .step        (step),
        .fix         (fix),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .last_step   (last_step),
        .product     (product)
    );

    // State register; an asynchronous reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, datapath strobes and handshake outputs; start is only honoured
    // in IDLE and DONE, so requests while busy are simply dropped.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        fix        = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last_step) begin
                    next_state = ST_FIX;
                end
            end
            ST_FIX: begin
                busy       = 1'b1;
                fix        = 1'b1;
                next_state = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    next_state = ST_RUN;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

endmodule
